lsu_mem_sequencer: RTL and testbench

LSU_MEM_SEQUENCER -- requirements
Module: lsu_mem_sequencer

---
 rtl/lsu_mem_sequencer_if.sv | 32 +++
 rtl/lsu_mem_sequencer.sv | 123 ++++++++++++
 tb/tb_lsu_mem_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_sequencer_if.sv
// Request/response and memory-port bundle of the LSU memory sequencer.
// slave = sequencer view, master = LSU/memory environment view.
interface lsu_mem_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// Sequences one byte/half/word load or store onto a 32-bit word memory,
// splitting misaligned accesses across two words and extending load data.
module lsu_mem_sequencer (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ACC1, ACC2, RDWAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        rq;
  logic [31:0] d1, rdata_q, ld_data, rd_sh;
  logic        accept, split;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  be_span;
  logic [63:0] wd_span, rd_span;

  assign accept = bus.req_valid && (state == IDLE);
  assign off    = rq.addr[1:0];

  // Lane masks and data are laid out over a two-word window; the upper half
  // belongs to the second access.
  always_comb begin
    case (rq.width)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    be_span = {4'b0000, mask} << off;
    wd_span = {32'h0, rq.wdata} << {off, 3'b000};
  end

  assign split = (be_span[7:4] != 4'b0000);

  // Non-split loads see their only word live in RDWAIT; split loads hold the
  // first word in d1 and see the second word live in RDWAIT.
  assign rd_span = split ? {bus.mem_rdata, d1} : {32'h0, bus.mem_rdata};
  assign rd_sh   = 32'(rd_span >> {off, 3'b000});

  always_comb begin
    case (rq.width)
      2'b00:   ld_data = rq.uns ? {24'h0, rd_sh[7:0]}  : {{24{rd_sh[7]}},  rd_sh[7:0]};
      2'b01:   ld_data = rq.uns ? {16'h0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: ld_data = rd_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.req_width == 2'b11) ? RESP : ACC1;
      ACC1:    state_nxt = split ? ACC2 : (rq.we ? RESP : RDWAIT);
      ACC2:    state_nxt = rq.we ? RESP : RDWAIT;
      RDWAIT:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rq      <= '0;
      d1      <= '0;
      rdata_q <= '0;
    end else begin
      if (accept)
        rq <= {bus.req_we, bus.req_width, bus.req_unsigned, bus.req_addr, bus.req_wdata};
      if (state == ACC2)   d1      <= bus.mem_rdata;
      if (state == RDWAIT) rdata_q <= ld_data;
      if (state == RESP)   rdata_q <= '0;
    end
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = 4'b0000;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = rdata_q;
    case (state)
      ACC1: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = rq.we;
        bus.mem_be    = be_span[3:0];
        bus.mem_addr  = rq.addr[31:2];
        bus.mem_wdata = wd_span[31:0];
      end
      ACC2: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = rq.we;
        bus.mem_be    = be_span[7:4];
        bus.mem_addr  = rq.addr[31:2] + 30'd1;
        bus.mem_wdata = wd_span[63:32];
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = (rq.width == 2'b11);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench: byte-addressed reference model predicts every output cycle,
// plus literal pins on the hand-worked scenarios.
module tb_lsu_mem_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_sequencer_if bus();
  lsu_mem_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        req_ready;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  logic [31:0] wmem [bit [29:0]];
  logic [7:0]  bmem [bit [31:0]];

  function automatic logic [31:0] env_rd(input logic [29:0] wa);
    return wmem.exists(wa) ? wmem[wa] : 32'h0;
  endfunction

  function automatic logic [7:0] brd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  // Word memory the sequencer talks to; idle read data is garbage on purpose.
  always @(posedge clk) begin
    logic [31:0] w;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= env_rd(bus.mem_addr);
    else                           bus.mem_rdata <= $urandom;
    if (bus.mem_en && bus.mem_we) begin
      w = env_rd(bus.mem_addr);
      for (int k = 0; k < 4; k++)
        if (bus.mem_be[k]) w[8*k +: 8] = bus.mem_wdata[8*k +: 8];
      wmem[bus.mem_addr] = w;
    end
  end

  task automatic preload(input logic [29:0] wa, input logic [31:0] v);
    wmem[wa] = v;
    for (int k = 0; k < 4; k++) bmem[{wa, 2'(k)}] = v[8*k +: 8];
  endtask

  // Reference: place each data byte at its byte address, split by word.
  task automatic model_push(input logic we, input logic [1:0] w, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd, input int keep);
    exp_t l[$];
    exp_t e, a1, a2;
    int n;
    bit sp;
    logic [31:0] v;
    e = '0; e.req_ready = 1'b1; l.push_back(e);
    if (w == 2'b11) begin
      e = '0; e.resp_valid = 1'b1; e.resp_err = 1'b1; l.push_back(e);
    end else begin
      n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
      a1 = '0; a1.mem_en = 1'b1; a1.mem_we = we; a1.mem_addr = a[31:2];
      a2 = a1; a2.mem_addr = a[31:2] + 30'd1;
      sp = 1'b0;
      for (int j = 0; j < 4; j++) begin
        int p;
        p = int'(a[1:0]) + j;
        if (p < 4) begin
          a1.mem_wdata[8*p +: 8] = wd[8*j +: 8];
          if (j < n) a1.mem_be[p] = 1'b1;
        end else begin
          a2.mem_wdata[8*(p-4) +: 8] = wd[8*j +: 8];
          if (j < n) begin a2.mem_be[p-4] = 1'b1; sp = 1'b1; end
        end
      end
      l.push_back(a1);
      if (sp) l.push_back(a2);
      if (!we) begin e = '0; l.push_back(e); end
      e = '0; e.resp_valid = 1'b1;
      if (!we) begin
        v = '0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = brd(a + 32'(j));
        if (!uns && n == 1 && v[7])  v[31:8]  = '1;
        if (!uns && n == 2 && v[15]) v[31:16] = '1;
        e.resp_rdata = v;
      end else begin
        for (int j = 0; j < n; j++) bmem[a + 32'(j)] = wd[8*j +: 8];
      end
      l.push_back(e);
    end
    for (int k = 0; k < l.size() && (keep < 0 || k < keep); k++) q.push_back(l[k]);
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (chk_en) begin
      if (q.size() != 0) e = q.pop_front();
      else begin e = '0; e.req_ready = 1'b1; end
      a = {bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr,
           bus.mem_wdata, bus.resp_valid, bus.resp_err, bus.resp_rdata};
      if (!e.resp_valid) begin e.resp_rdata = '0; a.resp_rdata = '0; end
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle @%0t act=%h exp=%h", $time, a, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin cyc(); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout act=%0d exp=0 pending cycles", q.size());
      q.delete();
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] w, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int keep = -1);
    wait_idle();
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_width = w;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    model_push(we, w, uns, a, wd, keep);
    cyc();
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom); bus.req_width = 2'($urandom);
    bus.req_unsigned = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_width = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) cyc();
    chk_en = 1'b1;
    pin("rst_ready", 32'(bus.req_ready), 32'h1);
    pin("rst_mem_en", 32'(bus.mem_en), 32'h0);
    pin("rst_resp", 32'(bus.resp_valid), 32'h0);
    rst_n = 1'b1;
    cyc();

    issue(1'b1, 2'b00, 1'b0, 32'h0, 32'hFFFFFF8F);
    pin("sb_be", 32'(bus.mem_be), 32'h1);
    pin("sb_addr", 32'(bus.mem_addr), 32'h0);
    pin("sb_wd", 32'(bus.mem_wdata[7:0]), 32'h8F);
    cyc();
    pin("sb_resp", 32'(bus.resp_valid), 32'h1);
    issue(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cyc(); cyc();
    pin("lb_s_valid", 32'(bus.resp_valid), 32'h1);
    pin("lb_s_data", bus.resp_rdata, 32'hFFFFFF8F);
    issue(1'b0, 2'b00, 1'b1, 32'h0, 32'h0);
    cyc(); cyc();
    pin("lb_u_data", bus.resp_rdata, 32'h0000008F);

    issue(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000ABCD);
    pin("sh3_c1_addr", 32'(bus.mem_addr), 32'h0);
    pin("sh3_c1_be", 32'(bus.mem_be), 32'h8);
    pin("sh3_c1_wd", 32'(bus.mem_wdata[31:24]), 32'hCD);
    cyc();
    pin("sh3_c2_addr", 32'(bus.mem_addr), 32'h1);
    pin("sh3_c2_be", 32'(bus.mem_be), 32'h1);
    pin("sh3_c2_wd", 32'(bus.mem_wdata[7:0]), 32'hAB);
    cyc();
    pin("sh3_resp", 32'(bus.resp_valid), 32'h1);
    issue(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    cyc(); cyc(); cyc();
    pin("lh3_data", bus.resp_rdata, 32'hFFFFABCD);

    wait_idle();
    preload(30'h0, 32'hBEEF0000);
    preload(30'h1, 32'h0000DEAD);
    issue(1'b0, 2'b10, 1'b1, 32'h2, 32'h0);
    cyc(); cyc(); cyc();
    pin("lw2_valid", 32'(bus.resp_valid), 32'h1);
    pin("lw2_data", bus.resp_rdata, 32'hDEADBEEF);

    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h1234);
    pin("err_valid", 32'(bus.resp_valid), 32'h1);
    pin("err_flag", 32'(bus.resp_err), 32'h1);
    pin("err_mem_en", 32'(bus.mem_en), 32'h0);
    issue(1'b0, 2'b11, 1'b1, 32'h0, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 32'hFFFFFFFD, 32'h11223344);
    pin("sw_wrap_c1_addr", 32'(bus.mem_addr), 32'h3FFFFFFF);
    pin("sw_wrap_c1_be", 32'(bus.mem_be), 32'hE);
    cyc();
    pin("sw_wrap_c2_addr", 32'(bus.mem_addr), 32'h0);
    pin("sw_wrap_c2_be", 32'(bus.mem_be), 32'h1);
    pin("sw_wrap_c2_wd", 32'(bus.mem_wdata[7:0]), 32'h11);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFD, 32'h0);
    cyc(); cyc(); cyc();
    pin("lw_wrap_data", bus.resp_rdata, 32'h11223344);

    issue(1'b0, 2'b00, 1'b0, 32'hFFFFFFFE, 32'h5555AAAA);
    issue(1'b0, 2'b01, 1'b1, 32'h1, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000005A);
    issue(1'b1, 2'b01, 1'b0, 32'h8, 32'h00008001);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h8, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h7, 32'h0);

    issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 3);
    cyc();
    pin("rst_acc2_addr", 32'(bus.mem_addr), 32'h1);
    rst_n = 1'b0;
    cyc();
    pin("rst_mid_ready", 32'(bus.req_ready), 32'h1);
    pin("rst_mid_mem_en", 32'(bus.mem_en), 32'h0);
    pin("rst_mid_resp", 32'(bus.resp_valid), 32'h0);
    rst_n = 1'b1;
    repeat (3) cyc();
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    wait_idle();
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
